fp_add_seq: RTL
===============

FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 4: exponent field width, bias 2^(EXP_W-1)-1.
REQ-002 SHALL have parameter MAN_W, default 3: stored mantissa width, hidden leading 1; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port go  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port sub  input  1  operation select: 0 computes a+b, 1 computes a-b; captured with operands.
REQ-007 SHALL have ports a, b  input  W each  operands {sign, exp, man}, captured on the edge that samples go=1.
REQ-008 SHALL have port sum  output  W  result register, held until the next result is written.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking sum valid.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have ports ovf, unf  output  1 each  overflow and underflow flags, updated together with sum.

Function
REQ-012 SHALL treat exp==0 as exact zero regardless of mantissa; no denormals, infinities or NaNs.
REQ-013 SHALL use effective sign of b = b.sign XOR sub.
REQ-014 SHALL sequence IDLE -> ALIGN -> ADD -> NORM -> [ROUND] -> DONE -> IDLE, one state per cycle; NORM repeats while a shift step occurs.
REQ-015 ALIGN SHALL order operands by {exp,man} magnitude; result sign and exponent taken from the larger; equal magnitudes select a.
REQ-016 ALIGN SHALL right-shift the smaller mantissa by the exponent difference in one cycle; shifts beyond MAN_W+3 yield 0.
REQ-017 ADD SHALL add mantissas when effective signs match, else subtract smaller from larger; the result never goes negative.
REQ-018 NORM SHALL perform one step per cycle: on carry, shift right 1 and exp+1; if hidden bit is 0 and mantissa nonzero, shift left 1 and exp-1; otherwise exit.
REQ-019 A zero mantissa after ADD SHALL produce sum = +0 (all bits 0) with ovf=unf=0.
REQ-020 An exponent increment past 2^EXP_W-1 SHALL saturate sum to {sign, all-ones exp, all-ones man} and set ovf=1.
REQ-021 An exponent decrement to 0 SHALL flush sum to +0 and set unf=1.
REQ-022 Latency SHALL be: done high in cycle 4+s+r after the edge that samples go, where s = NORM shift steps and r = 1 with rounding compiled in, else 0.
REQ-023 go asserted while busy=1 SHALL be ignored; go held high through DONE SHALL start a new operation on return to IDLE.
REQ-024 Either operand being zero SHALL return the other operand, sign-adjusted for sub, through the normal path.

Reset
REQ-025 clr SHALL force IDLE and sum=0, done=0, busy=0, ovf=0, unf=0 immediately, independent of clk.
REQ-026 clr mid-operation SHALL abort with no done pulse; the next go after release SHALL start a clean operation.

Configuration
REQ-027 Macro FP_ADD_SEQ_RNE_EN defined: the datapath SHALL carry guard, round and sticky bits; the ROUND state SHALL round to nearest, ties to even.
REQ-028 With FP_ADD_SEQ_RNE_EN defined, a rounding carry-out SHALL renormalise within ROUND (shift right, exp+1, overflow check per REQ-020).
REQ-029 FP_ADD_SEQ_RNE_EN undefined: bits below the mantissa LSB SHALL be truncated, the ROUND state SHALL be omitted, and r=0.

Verification (defaults EXP_W=4, MAN_W=3)
REQ-030 a=0x38, b=0x38, sub=0 -> sum=0x40, ovf=unf=0, done in cycle 5 after go (no rounding) or cycle 6 (rounding).
REQ-031 a=0x39, b=0x38, sub=1 -> sum=0x20 after 3 NORM left shifts; a=0x38, b=0x38, sub=1 -> sum=0x00.
REQ-032 a=0x39, b=0x18, sub=0 -> sum=0x3A with FP_ADD_SEQ_RNE_EN, 0x39 without.
REQ-033 a=0x7F, b=0x7F -> sum=0x7F, ovf=1; a=0x09, b=0x88 -> sum=0x00, unf=1.
REQ-034 clr pulsed during NORM -> all outputs 0 at once, no done pulse; a following go with a=0x3C, b=0x3C -> sum=0x44.
REQ-035 go re-pulsed while busy -> ignored; a zero operand (a=0x00, b=0xC0, sub=1) -> sum=0x40.

Source files
------------

// File: rtl/fp_add_seq.sv
// fp_add_seq: sequential floating-point adder/subtractor for a small
// {sign, exp, man} format (bias 2^(EXP_W-1)-1, hidden leading one,
// exp==0 is exact zero, no denormals/infinities/NaNs).
// One state per cycle: IDLE -> ALIGN -> ADD -> NORM (repeats per shift step)
// -> [ROUND] -> DONE -> IDLE.
// Optional feature: define FP_ADD_SEQ_RNE_EN to carry guard/round/sticky bits
// and add a ROUND state (round to nearest, ties to even). Without it, bits
// below the mantissa LSB are truncated and ROUND does not exist.
//
// Handshake: go is sampled only in IDLE; the edge that samples go=1 also
// captures a, b and sub. busy is high in every state except IDLE. done is a
// one-cycle pulse in DONE; sum/ovf/unf are written on entry to DONE and held
// until the next result. clr aborts any operation immediately.
module fp_add_seq #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   go,
    input  logic                   sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic [EXP_W+MAN_W:0]   sum,
    output logic                   done,
    output logic                   busy,
    output logic                   ovf,
    output logic                   unf,
    output logic [2:0]             dbg_state_o
);

    localparam int W = 1 + EXP_W + MAN_W;
`ifdef FP_ADD_SEQ_RNE_EN
    localparam int GRS = 3;
`else
    localparam int GRS = 0;
`endif
    // Working mantissa: hidden bit, stored bits, optional guard/round/sticky.
    localparam int M      = MAN_W + 1 + GRS;
    localparam int MAX_SH = MAN_W + 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
`ifdef FP_ADD_SEQ_RNE_EN
        S_ROUND = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     op_a_q, op_b_q;   // op_b_q holds the effective sign of b
    logic             sign_q, eff_sub_q;
    logic [EXP_W-1:0] exp_q;
    logic [M-1:0]     big_q, small_q;
    logic [M:0]       mant_q;           // bit M is the adder carry
    logic [W-1:0]     sum_q;
    logic             ovf_q, unf_q;

    // Expand a field to the working mantissa; exp==0 means exact zero.
    function automatic logic [M-1:0] ext_mant(input logic [EXP_W-1:0] e,
                                              input logic [MAN_W-1:0] m);
        logic [M-1:0] r;
        r = '0;
        if (e != '0) r[M-1 -: MAN_W+1] = {1'b1, m};
        return r;
    endfunction

    // ALIGN datapath: order by magnitude, shift the smaller operand right.
    logic             a_ge_b;
    logic             big_sign;
    logic [EXP_W-1:0] big_exp, sml_exp, diff;
    logic [MAN_W-1:0] big_man, sml_man;
    logic [M-1:0]     sml_ext, sml_shift;
`ifdef FP_ADD_SEQ_RNE_EN
    logic             sh_lost;
`endif

    assign a_ge_b = (op_a_q[W-2:0] >= op_b_q[W-2:0]);

    // Operand ordering and alignment shifter.
    always_comb begin
        big_sign  = a_ge_b ? op_a_q[W-1]          : op_b_q[W-1];
        big_exp   = a_ge_b ? op_a_q[W-2 -: EXP_W] : op_b_q[W-2 -: EXP_W];
        big_man   = a_ge_b ? op_a_q[MAN_W-1:0]    : op_b_q[MAN_W-1:0];
        sml_exp   = a_ge_b ? op_b_q[W-2 -: EXP_W] : op_a_q[W-2 -: EXP_W];
        sml_man   = a_ge_b ? op_b_q[MAN_W-1:0]    : op_a_q[MAN_W-1:0];
        diff      = big_exp - sml_exp;
        sml_ext   = ext_mant(sml_exp, sml_man);
        sml_shift = '0;
`ifdef FP_ADD_SEQ_RNE_EN
        sh_lost   = 1'b0;
`endif
        if (int'(diff) <= MAX_SH) begin
            sml_shift = sml_ext >> diff;
`ifdef FP_ADD_SEQ_RNE_EN
            // Bits pushed past the LSB collapse into the sticky bit.
            sh_lost      = |(sml_ext & ~({M{1'b1}} << diff));
            sml_shift[0] = sml_shift[0] | sh_lost;
`endif
        end
    end

    // NORM step decode.
    logic       norm_zero, norm_carry, norm_left, exp_max, exp_one;
    logic [M:0] mant_shr;

    assign norm_zero  = (mant_q == '0);
    assign norm_carry = mant_q[M];
    assign norm_left  = !mant_q[M] && !mant_q[M-1] && !norm_zero;
    assign exp_max    = (exp_q == '1);
    assign exp_one    = (exp_q == EXP_W'(1));
`ifdef FP_ADD_SEQ_RNE_EN
    assign mant_shr   = {1'b0, mant_q[M:2], mant_q[1] | mant_q[0]};

    // Round to nearest even on the guard/round/sticky bits.
    logic             rnd_up;
    logic [MAN_W+1:0] rnd_m;
    assign rnd_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    assign rnd_m  = {1'b0, mant_q[M-1:GRS]} + (MAN_W+2)'(rnd_up);
`else
    assign mant_shr   = {1'b0, mant_q[M:1]};
`endif

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM: begin
                if ((norm_carry && exp_max) || (norm_left && exp_one))
                    state_d = S_DONE;
                else if (norm_carry || norm_left)
                    state_d = S_NORM;
                else
`ifdef FP_ADD_SEQ_RNE_EN
                    state_d = S_ROUND;
`else
                    state_d = S_DONE;
`endif
            end
`ifdef FP_ADD_SEQ_RNE_EN
            S_ROUND: state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and result registers, advanced by the current state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            big_q     <= '0;
            small_q   <= '0;
            mant_q    <= '0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        op_a_q <= a;
                        op_b_q <= {b[W-1] ^ sub, b[W-2:0]};
                    end
                end
                S_ALIGN: begin
                    sign_q    <= big_sign;
                    exp_q     <= big_exp;
                    big_q     <= ext_mant(big_exp, big_man);
                    small_q   <= sml_shift;
                    eff_sub_q <= op_a_q[W-1] ^ op_b_q[W-1];
                end
                S_ADD: begin
                    // big_q >= small_q, so the difference is never negative.
                    if (eff_sub_q) mant_q <= {1'b0, big_q} - {1'b0, small_q};
                    else           mant_q <= {1'b0, big_q} + {1'b0, small_q};
                end
                S_NORM: begin
                    if (norm_carry) begin
                        if (exp_max) begin
                            sum_q <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                            ovf_q <= 1'b1;
                            unf_q <= 1'b0;
                        end else begin
                            mant_q <= mant_shr;
                            exp_q  <= exp_q + 1'b1;
                        end
                    end else if (norm_left) begin
                        if (exp_one) begin
                            sum_q <= '0;
                            ovf_q <= 1'b0;
                            unf_q <= 1'b1;
                        end else begin
                            mant_q <= {mant_q[M-1:0], 1'b0};
                            exp_q  <= exp_q - 1'b1;
                        end
                    end else begin
`ifndef FP_ADD_SEQ_RNE_EN
                        sum_q <= norm_zero ? '0
                                           : {sign_q, exp_q, mant_q[M-2 -: MAN_W]};
                        ovf_q <= 1'b0;
                        unf_q <= 1'b0;
`endif
                    end
                end
`ifdef FP_ADD_SEQ_RNE_EN
                S_ROUND: begin
                    ovf_q <= 1'b0;
                    unf_q <= 1'b0;
                    if (norm_zero) begin
                        sum_q <= '0;
                    end else if (rnd_m[MAN_W+1]) begin
                        // Rounding carried out: mantissa becomes 1.000, exp+1.
                        if (exp_max) begin
                            sum_q <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                            ovf_q <= 1'b1;
                        end else begin
                            sum_q <= {sign_q, exp_q + 1'b1, rnd_m[MAN_W:1]};
                        end
                    end else begin
                        sum_q <= {sign_q, exp_q, rnd_m[MAN_W-1:0]};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign sum         = sum_q;
    assign ovf         = ovf_q;
    assign unf         = unf_q;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule
